// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: PC register, IF/ID pipeline register, stall and redirect/flush.
// Optional macro IFU_ALIGN_CHECK_EN adds a sticky fault state for misaligned redirect targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        fetch_fault
);

    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] idPc_q, idPc_d;
    logic [31:0] idPc4_q, idPc4_d;
    logic [31:0] pcPlus4;

    assign pcPlus4 = pc_q + 32'd4;

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic {RUN, FAULT} state_t;
    state_t state_q, state_d;

    // Fault is sticky: once entered, only reset returns to RUN.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        idPc_d  = idPc_q;
        idPc4_d = idPc4_q;
        if (state_q == FAULT) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (redirect_valid) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = FAULT;
            end else begin
                pc_d = redirect_pc;
            end
        end else if (!stall) begin
            instr_d = imem_instr;
            idPc_d  = pc_q;
            idPc4_d = pcPlus4;
            valid_d = 1'b1;
            pc_d    = pcPlus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign fetch_fault = (state_q == FAULT);
`else
    // Without alignment checking, targets are silently word-aligned.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        idPc_d  = idPc_q;
        idPc4_d = idPc4_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (!stall) begin
            instr_d = imem_instr;
            idPc_d  = pc_q;
            idPc4_d = pcPlus4;
            valid_d = 1'b1;
            pc_d    = pcPlus4;
        end
    end

    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            idPc_q  <= 32'h0000_0000;
            idPc4_q <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            idPc_q  <= idPc_d;
            idPc4_q <= idPc4_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = idPc_q;
    assign if_id_pc4   = idPc4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps followed by random traffic
// compared against a behavioural fetch model.
module tb_instr_fetch_unit;

`ifdef IFU_ALIGN_CHECK_EN
    localparam bit AlignEn = 1'b1;
`else
    localparam bit AlignEn = 1'b0;
`endif
    localparam logic [31:0] Nop = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        fetch_fault;

    logic [31:0] mem [1024];

    int testCount = 0;
    int failCount = 0;

    logic [31:0] mPc, mInstr, mIdPc, mIdPc4;
    logic        mValid, mFault;

    instr_fetch_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4),
        .fetch_fault(fetch_fault)
    );

    // Instruction memory: combinational read, word-indexed, aliases every 4 KB.
    assign imem_instr = mem[imem_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: one clock edge of the fetch stage, in priority order.
    task automatic modelEdge(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
        if (!r) begin
            mPc = 32'h0; mValid = 1'b0; mInstr = Nop; mIdPc = 32'h0; mIdPc4 = 32'h0; mFault = 1'b0;
        end else if (mFault) begin
            mValid = 1'b0; mInstr = Nop;
        end else if (rv) begin
            mValid = 1'b0; mInstr = Nop;
            if (AlignEn && rpc[1:0] != 2'b00) mFault = 1'b1;
            else mPc = rpc & 32'hFFFF_FFFC;
        end else if (!s) begin
            mInstr = mem[mPc[11:2]];
            mIdPc  = mPc;
            mIdPc4 = mPc + 32'd4;
            mValid = 1'b1;
            mPc    = mPc + 32'd4;
        end
    endtask

    task automatic checkOutput();
        checkOne("imem_addr", imem_addr, mPc);
        checkOne("if_id_valid", {31'b0, if_id_valid}, {31'b0, mValid});
        checkOne("if_id_instr", if_id_instr, mInstr);
        checkOne("if_id_pc", if_id_pc, mIdPc);
        checkOne("if_id_pc4", if_id_pc4, mIdPc4);
        checkOne("fetch_fault", {31'b0, fetch_fault}, {31'b0, mFault});
    endtask

    // Drive inputs just after an edge, clock one edge, then check #1 after it.
    task automatic applyStimulus(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
        rst_n = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
        modelEdge(r, s, rv, rpc);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic        rr, rs, rrv;
        logic [31:0] rpc;

        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h8C01_0000;
        mem[1] = 32'h8C02_0004;
        mem[2] = 32'h8C03_0008;
        #1;

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOne("reset_addr", imem_addr, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOne("fetch1_instr", if_id_instr, 32'h8C01_0000);
        checkOne("fetch1_pc", if_id_pc, 32'h0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOne("stall_instr", if_id_instr, 32'h8C01_0000);
            checkOne("stall_addr", imem_addr, 32'h4);
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOne("fetch2_instr", if_id_instr, 32'h8C02_0004);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOne("fetch3_instr", if_id_instr, 32'h8C03_0008);
        checkOne("fetch3_pc", if_id_pc, 32'h8);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOne("pre_redirect_addr", imem_addr, 32'h1C);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h24);
        checkOne("redir_valid", {31'b0, if_id_valid}, 32'h0);
        checkOne("redir_addr", imem_addr, 32'h24);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOne("redir_target_pc", if_id_pc, 32'h24);

        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        checkOne("redir_stall_addr", imem_addr, 32'h40);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOne("wrap_addr", imem_addr, 32'h0);
        checkOne("wrap_pc4", if_id_pc4, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h26);
        if (AlignEn) begin
            checkOne("fault_set", {31'b0, fetch_fault}, 32'h1);
            checkOne("fault_pc_frozen", imem_addr, 32'h0);
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h10);
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOne("fault_sticky", {31'b0, fetch_fault}, 32'h1);
        end else begin
            checkOne("align_force_addr", imem_addr, 32'h24);
            checkOne("no_fault", {31'b0, fetch_fault}, 32'h0);
        end

        applyStimulus(1'b0, 1'b1, 1'b1, 32'h80);
        checkOne("reset_override_addr", imem_addr, 32'h0);
        checkOne("reset_clears_fault", {31'b0, fetch_fault}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            rr  = ($urandom_range(0, 49) != 0);
            rs  = ($urandom_range(0, 3) == 0);
            rrv = ($urandom_range(0, 5) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) rpc[31:12] = 20'h0;
            applyStimulus(rr, rs, rrv, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Front end of the MIPS datapath: owns the program counter and drives the byte address into the instruction memory.
- Captures the returned instruction into the IF/ID pipeline register together with its PC and PC+4.
- Supports pipeline stall, taken-branch/jump redirect with wrong-path flush and, optionally, misaligned-target fault detection.
- Sits between the instruction memory (combinational read, word-indexed by `address[11:2]`) and the decode stage.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded by reset.
- `NOP_INSTR`, default `32'h0000_0000`: encoding written into `if_id_instr` on reset and flush (`sll $0,$0,0`).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `stall` in 1: hold PC and IF/ID contents (decode hazard).
- `redirect_valid` in 1: taken branch/jump resolved downstream this cycle.
- `redirect_pc` in 32: byte address of the redirect target.
- `imem_addr` out 32: byte address to the instruction memory; equals PC register (combinational).
- `imem_instr` in 32: instruction returned combinationally for `imem_addr`.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_instr` out 32: registered instruction.
- `if_id_pc` out 32: address of `if_id_instr`.
- `if_id_pc4` out 32: `if_id_pc + 4`.
- `fetch_fault` out 1: sticky misaligned-target flag (see Configuration).

## Operation

- State machine: `RUN`, `FAULT`. Reset enters `RUN`. `FAULT` exists only with the macro defined.
- Priority each edge in `RUN`: reset > redirect > stall > normal fetch.
- Normal fetch (`stall=0`, `redirect_valid=0`): `if_id_instr<=imem_instr`, `if_id_pc<=pc`, `if_id_pc4<=pc+4`, `if_id_valid<=1`, `pc<=pc+4`.
- Stall: PC and all IF/ID registers hold their values. `imem_addr` remains stable.
- Redirect, whether stalled or not: `pc<=redirect_pc`; IF/ID is flushed (`if_id_valid<=0`, `if_id_instr<=NOP_INSTR`; `if_id_pc` and `if_id_pc4` hold). The fetched wrong-path instruction is discarded.
- Arithmetic: `pc+4` is a 32-bit add and wraps modulo 2^32 (`32'hFFFF_FFFC -> 32'h0000_0000`). Memory aliasing above 4 KB is the memory's concern, not this block's.
- `FAULT`: PC frozen; IF/ID shows a bubble (`valid=0`, NOP). Further redirects and stalls are ignored. Only reset exits.

## Timing

- Reset values: `pc=RESET_PC` (so `imem_addr=RESET_PC`), `if_id_valid=0`, `if_id_instr=NOP_INSTR`, `if_id_pc=0`, `if_id_pc4=0`, `fetch_fault=0`, state `RUN`.
- Latency: an instruction at address A appears on `if_id_*` one edge after `imem_addr=A`.
- Throughput: one instruction per cycle when unstalled.
- Redirect: the target address is on `imem_addr` the cycle after `redirect_valid` is sampled. The target instruction reaches IF/ID one edge later, so the bubble is exactly 1 cycle.
- `rst_n` low mid-stream overrides stall and redirect on that edge.

## Configuration

- Macro: `IFU_ALIGN_CHECK_EN`.
- Defined: a redirect with `redirect_pc[1:0]!=0` sets `fetch_fault<=1` and enters `FAULT`. PC is not updated and IF/ID is flushed.
- Undefined: `redirect_pc[1:0]` is forced to `2'b00` before loading, `fetch_fault` is tied 0, and no `FAULT` state exists.

## Test plan

- Reset then free run with memory words `8C010000, 8C020004, 8C030008`: after edges 1/2/3, `if_id_instr` = those words, `if_id_pc` = 0/4/8, `if_id_valid=1`.
- Stall held 3 cycles after the first fetch: `if_id_instr` stays `8C010000` and `imem_addr` stays `4`. Fetch resumes with `8C020004` on release.
- `redirect_valid=1`, `redirect_pc=32'h24` while `pc=0x1C`: the next edge gives `if_id_valid=0`, `if_id_instr=0`, `imem_addr=0x24`. The edge after gives `if_id_pc=0x24`.
- Redirect together with `stall=1`: the redirect wins, so the PC loads the target and IF/ID is flushed.
- PC wrap: redirect to `32'hFFFF_FFFC`, then fetch: `imem_addr` becomes `0`, `if_id_pc4=0`.
- `redirect_pc=32'h26`:
  - With `IFU_ALIGN_CHECK_EN`: `fetch_fault=1`, PC frozen; it clears only after `rst_n=0`.
  - Without the macro: `imem_addr=0x24`, `fetch_fault=0`.
